// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file read addressing, load-use stall, HLT parking, ID/EX register.
// Optional build macro LOAD_USE_STALL_EN enables load-use hazard detection (off for MEM->EX forwarding builds).
module decode_stage #(
  parameter int         DATA_W  = 16,
  parameter logic [3:0] HLT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [15:0]       if_pc,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [3:0]        ex_dst,
  output logic              if_stall,
  output logic [3:0]        rf_src1,
  output logic [3:0]        rf_src2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic              idex_valid,
  output logic              idex_wen,
  output logic              idex_is_load,
  output logic              idex_is_store,
  output logic              idex_halt,
  output logic [3:0]        idex_opc,
  output logic [3:0]        idex_dst,
  output logic [DATA_W-1:0] idex_a,
  output logic [DATA_W-1:0] idex_b,
  output logic [DATA_W-1:0] idex_imm,
  output logic [15:0]       idex_pc
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state;
  logic [3:0]        opc, rd, rs, rt;
  logic              useSrc1, useSrc2;
  logic              decWen, decLoad, decStore, decHalt;
  logic [DATA_W-1:0] decB, decImm;
  logic              hz, halted, accept;

  // Sign-extend a 9-bit field and scale by 2 (halfword offsets).
  function automatic logic [DATA_W-1:0] sextShl(input logic signed [8:0] v);
    logic signed [DATA_W-1:0] w;
    w = {{(DATA_W-9){v[8]}}, v};
    return w <<< 1;
  endfunction

  assign opc = if_instr[15:12];
  assign rd  = if_instr[11:8];
  assign rs  = if_instr[7:4];
  assign rt  = if_instr[3:0];
  assign decHalt = (opc == HLT_OPC);

  always_comb begin
    rf_src1  = rs;
    rf_src2  = rt;
    useSrc1  = 1'b1;
    useSrc2  = 1'b0;
    decB     = rf_data2;
    decImm   = '0;
    decWen   = 1'b0;
    decLoad  = 1'b0;
    decStore = 1'b0;
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        useSrc2 = 1'b1;
        decWen  = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        decB   = DATA_W'(rt);
        decImm = DATA_W'(rt);
        decWen = 1'b1;
      end
      4'h8: begin
        decImm  = sextShl({{5{rt[3]}}, rt});
        decWen  = 1'b1;
        decLoad = 1'b1;
      end
      4'h9: begin
        rf_src2  = rd;
        useSrc2  = 1'b1;
        decImm   = sextShl({{5{rt[3]}}, rt});
        decStore = 1'b1;
      end
      4'hA, 4'hB: begin
        rf_src1 = rd;
        decImm  = DATA_W'(if_instr[7:0]);
        decWen  = 1'b1;
      end
      4'hC: decImm = sextShl(if_instr[8:0]);
      4'hD: ;
      4'hE: decWen = 1'b1;
      default: useSrc1 = 1'b0;
    endcase
  end

`ifdef LOAD_USE_STALL_EN
  assign hz = ex_valid & ex_is_load & if_valid &
              ((useSrc1 & (ex_dst == rf_src1)) | (useSrc2 & (ex_dst == rf_src2)));
`else
  logic unusedHz;
  assign unusedHz = ^{ex_valid, ex_is_load, ex_dst, useSrc1, useSrc2};
  assign hz = 1'b0;
`endif

  assign halted   = (state == HALTED);
  // Flush redirects fetch, so it overrides a hazard stall; HALTED always stalls.
  assign if_stall = halted | (hz & ~flush);
  assign accept   = if_valid & ~flush & ~halted & ~hz;

  // ID/EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      idex_valid    <= 1'b0;
      idex_wen      <= 1'b0;
      idex_is_load  <= 1'b0;
      idex_is_store <= 1'b0;
      idex_halt     <= 1'b0;
      idex_opc      <= '0;
      idex_dst      <= '0;
      idex_a        <= '0;
      idex_b        <= '0;
      idex_imm      <= '0;
      idex_pc       <= '0;
    end else begin
      idex_valid    <= accept;
      idex_wen      <= accept & decWen;
      idex_is_load  <= accept & decLoad;
      idex_is_store <= accept & decStore;
      idex_halt     <= accept & decHalt;
      if (accept) begin
        idex_opc <= opc;
        idex_dst <= rd;
        idex_a   <= rf_data1;
        idex_b   <= decB;
        idex_imm <= decImm;
        idex_pc  <= if_pc;
        if (decHalt) state <= HALTED;
      end
    end
  end

endmodule
